// File: rtl/uart_pkg.sv
// Shared UART constants and receive-path FSM state type.
// The baud/clock figures are also used by uart_send_ctrl.
package uart_pkg;

  localparam int unsigned BYTE_W       = 8;
  localparam int unsigned CLK_FREQ_HZ  = 50_000_000;
  localparam int unsigned BAUD_RATE    = 115_200;

  // Roughly 3.5 character times of line silence at CLK_FREQ_HZ / BAUD_RATE.
  localparam int unsigned IDLE_CYCLES_DEFAULT = 16_710;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RECV = 1'b1
  } rx_state_e;

endpackage : uart_pkg

// File: rtl/uart_rx_idle_timer.sv
// Inter-byte idle timer: restarts on demand, counts while enabled and
// saturates at IDLE_CYCLES-1, flagging terminal count while enabled there.
module uart_rx_idle_timer #(
  parameter int unsigned IDLE_CYCLES = uart_pkg::IDLE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic restart,
  input  logic enable,
  output logic tc
);

  localparam int unsigned TMR_W = $clog2(IDLE_CYCLES);
  localparam logic [TMR_W-1:0] TC_VAL = TMR_W'(IDLE_CYCLES - 1);

  logic [TMR_W-1:0] cnt_q;
  logic [TMR_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != TC_VAL)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = enable && (cnt_q == TC_VAL);

endmodule : uart_rx_idle_timer

// File: rtl/uart_recv_ctrl.sv
// UART receive controller: forwards received bytes to the RX FIFO, reports
// drops and marks packet ends on idle gaps. Drop counter gated by UART_RX_OVF_CNT_EN.
module uart_recv_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned IDLE_CYCLES = IDLE_CYCLES_DEFAULT,
  parameter int unsigned OVF_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 uart_rx_done,
  input  logic [BYTE_W-1:0]    uart_rx_data,
  input  logic                 uart_rx_frame_err,
  input  logic                 fifo_full,
  output logic                 fifo_wr_req,
  output logic [BYTE_W-1:0]    fifo_wr_data,
  output logic                 rx_drop,
  output logic                 rx_packet_end,
  input  logic                 ovf_clear,
  output logic [OVF_CNT_W-1:0] ovf_count
);

  rx_state_e state_q;
  rx_state_e state_d;

  logic              wr_req_q,  wr_req_d;
  logic [BYTE_W-1:0] wr_data_q, wr_data_d;
  logic              drop_q,    drop_d;
  logic              pkt_end_q, pkt_end_d;

  logic byte_ok;
  logic byte_accept;
  logic full_drop;
  logic any_drop;
  logic tmr_restart;
  logic tmr_enable;
  logic tmr_tc;

  assign byte_ok     = uart_rx_done && !uart_rx_frame_err;
  assign byte_accept = byte_ok && !fifo_full;
  assign full_drop   = byte_ok && fifo_full;
  assign any_drop    = uart_rx_done && (uart_rx_frame_err || fifo_full);

  // Frame-error bytes are treated as line noise and do not extend a packet.
  assign tmr_restart = byte_ok;
  assign tmr_enable  = (state_q == S_RECV);

  uart_rx_idle_timer #(
    .IDLE_CYCLES (IDLE_CYCLES)
  ) u_idle_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .restart (tmr_restart),
    .enable  (tmr_enable),
    .tc      (tmr_tc)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (byte_accept) begin
          state_d = S_RECV;
        end
      end
      S_RECV: begin
        // A byte coinciding with terminal count keeps the packet open.
        if (tmr_tc && !uart_rx_done) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_req_d  = byte_accept;
    wr_data_d = byte_accept ? uart_rx_data : wr_data_q;
    drop_d    = any_drop;
    pkt_end_d = (state_q == S_RECV) && tmr_tc && !uart_rx_done;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_req_q  <= 1'b0;
      wr_data_q <= '0;
      drop_q    <= 1'b0;
      pkt_end_q <= 1'b0;
    end else begin
      wr_req_q  <= wr_req_d;
      wr_data_q <= wr_data_d;
      drop_q    <= drop_d;
      pkt_end_q <= pkt_end_d;
    end
  end

  assign fifo_wr_req   = wr_req_q;
  assign fifo_wr_data  = wr_data_q;
  assign rx_drop       = drop_q;
  assign rx_packet_end = pkt_end_q;

`ifdef UART_RX_OVF_CNT_EN
  logic [OVF_CNT_W-1:0] ovf_q;
  logic [OVF_CNT_W-1:0] ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clear) begin
      ovf_d = full_drop ? OVF_CNT_W'(1) : '0;
    end else if (full_drop && (ovf_q != '1)) begin
      ovf_d = ovf_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf_count = ovf_q;
`else
  logic unused_ovf_inputs;
  assign unused_ovf_inputs = ovf_clear ^ full_drop;
  assign ovf_count         = '0;
`endif

endmodule : uart_recv_ctrl

// File: tb/tb_uart_recv_ctrl.sv
// Directed bench for uart_recv_ctrl: vector table plus multi-cycle sequences.
// Counter expectations follow UART_RX_OVF_CNT_EN.
module tb_uart_recv_ctrl;

  localparam int unsigned IDLE = 4;
  localparam int unsigned OVW  = 8;
`ifdef UART_RX_OVF_CNT_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           uart_rx_done = 1'b0;
  logic [7:0]     uart_rx_data = '0;
  logic           uart_rx_frame_err = 1'b0;
  logic           fifo_full = 1'b0;
  logic           fifo_wr_req;
  logic [7:0]     fifo_wr_data;
  logic           rx_drop;
  logic           rx_packet_end;
  logic           ovf_clear = 1'b0;
  logic [OVW-1:0] ovf_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_recv_ctrl #(
    .IDLE_CYCLES (IDLE),
    .OVF_CNT_W   (OVW)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .uart_rx_done      (uart_rx_done),
    .uart_rx_data      (uart_rx_data),
    .uart_rx_frame_err (uart_rx_frame_err),
    .fifo_full         (fifo_full),
    .fifo_wr_req       (fifo_wr_req),
    .fifo_wr_data      (fifo_wr_data),
    .rx_drop           (rx_drop),
    .rx_packet_end     (rx_packet_end),
    .ovf_clear         (ovf_clear),
    .ovf_count         (ovf_count)
  );

  typedef struct {
    logic       done;
    logic [7:0] data;
    logic       ferr;
    logic       full;
    logic       clr;
    logic       wr;
    logic [7:0] wdata;
    logic       drop;
    logic       pend;
    logic [7:0] ovf;
  } vec_t;

  vec_t vq[$];

  function automatic logic [7:0] ovf_exp(input logic [7:0] v);
    return OVF_EN ? v : 8'd0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic done, input logic [7:0] data, input logic ferr,
                     input logic full, input logic clr, input logic wr,
                     input logic [7:0] wdata, input logic drop, input logic pend,
                     input logic [7:0] ovf);
    vec_t v;
    v.done = done; v.data = data; v.ferr = ferr; v.full = full; v.clr = clr;
    v.wr = wr; v.wdata = wdata; v.drop = drop; v.pend = pend; v.ovf = ovf;
    vq.push_back(v);
  endtask

  task automatic idle(input int n, input logic [7:0] wdata, input logic [7:0] ovf);
    for (int i = 0; i < n; i++) add(0, 8'h00, 0, 0, 0, 0, wdata, 0, 0, ovf);
  endtask

  // Drive inputs on the falling edge, sample just after the next rising edge.
  task automatic cycle(input logic done, input logic [7:0] data, input logic ferr,
                       input logic full, input logic clr);
    @(negedge clk);
    uart_rx_done = done; uart_rx_data = data; uart_rx_frame_err = ferr;
    fifo_full = full; ovf_clear = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int drops;
    int writes;
    int k;
    bit seen;

    add(0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 8'd0);   // 0: reset state
    add(1, 8'hA5, 0, 0, 0, 1, 8'hA5, 0, 0, 8'd0);   // 1: single byte
    idle(3, 8'hA5, 8'd0);                           // 2-4
    add(0, 8'h00, 0, 0, 0, 0, 8'hA5, 0, 1, 8'd0);   // 5: packet end
    idle(1, 8'hA5, 8'd0);                           // 6
    add(1, 8'h11, 0, 0, 0, 1, 8'h11, 0, 0, 8'd0);   // 7-9: back-to-back
    add(1, 8'h22, 0, 0, 0, 1, 8'h22, 0, 0, 8'd0);
    add(1, 8'h33, 0, 0, 0, 1, 8'h33, 0, 0, 8'd0);
    idle(3, 8'h33, 8'd0);                           // 10-12
    add(0, 8'h00, 0, 0, 0, 0, 8'h33, 0, 1, 8'd0);   // 13
    add(1, 8'h77, 1, 0, 0, 0, 8'h33, 1, 0, 8'd0);   // 14: frame err in idle
    idle(6, 8'h33, 8'd0);                           // 15-20
    add(1, 8'h55, 0, 1, 0, 0, 8'h33, 1, 0, 8'd1);   // 21: full drop
    idle(5, 8'h33, 8'd1);                           // 22-26
    add(1, 8'h9C, 0, 0, 0, 1, 8'h9C, 0, 0, 8'd1);   // 27
    add(1, 8'hAB, 1, 0, 0, 0, 8'h9C, 1, 0, 8'd1);   // 28: frame err in recv
    idle(2, 8'h9C, 8'd1);                           // 29-30
    add(0, 8'h00, 0, 0, 0, 0, 8'h9C, 0, 1, 8'd1);   // 31: not extended
    add(1, 8'h40, 0, 0, 0, 1, 8'h40, 0, 0, 8'd1);   // 32
    idle(2, 8'h40, 8'd1);                           // 33-34
    add(1, 8'h66, 0, 1, 0, 0, 8'h40, 1, 0, 8'd2);   // 35: full drop restarts timer
    idle(3, 8'h40, 8'd2);                           // 36-38
    add(0, 8'h00, 0, 0, 0, 0, 8'h40, 0, 1, 8'd2);   // 39
    add(1, 8'hC3, 0, 0, 0, 1, 8'hC3, 0, 0, 8'd2);   // 40
    idle(3, 8'hC3, 8'd2);                           // 41-43
    add(1, 8'hD4, 0, 0, 0, 1, 8'hD4, 0, 0, 8'd2);   // 44: byte at terminal count
    idle(3, 8'hD4, 8'd2);                           // 45-47
    add(0, 8'h00, 0, 0, 0, 0, 8'hD4, 0, 1, 8'd2);   // 48
    add(0, 8'h00, 0, 0, 1, 0, 8'hD4, 0, 0, 8'd0);   // 49: clear
    add(1, 8'h5A, 0, 1, 1, 0, 8'hD4, 1, 0, 8'd1);   // 50: clear + overflow
    idle(1, 8'hD4, 8'd1);                           // 51

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vq[i]) begin
      cycle(vq[i].done, vq[i].data, vq[i].ferr, vq[i].full, vq[i].clr);
      check($sformatf("v%0d.wr", i),   fifo_wr_req,   vq[i].wr);
      check($sformatf("v%0d.data", i), fifo_wr_data,  vq[i].wdata);
      check($sformatf("v%0d.drop", i), rx_drop,       vq[i].drop);
      check($sformatf("v%0d.pend", i), rx_packet_end, vq[i].pend);
      check($sformatf("v%0d.ovf", i),  ovf_count,     ovf_exp(vq[i].ovf));
    end

    // Saturation: 300 full drops back to back.
    drops = 0;
    writes = 0;
    for (int i = 0; i < 300; i++) begin
      cycle(1, 8'h55, 0, 1, 0);
      if (rx_drop) drops++;
      if (fifo_wr_req) writes++;
    end
    cycle(0, 8'h00, 0, 0, 0);
    check("sat.drops", drops, 300);
    check("sat.writes", writes, 0);
    check("sat.ovf", ovf_count, ovf_exp(8'd255));

    // Asynchronous reset while a write strobe is high mid-packet.
    cycle(1, 8'hE1, 0, 0, 0);
    check("rst.pre_wr", fifo_wr_req, 1);
    @(negedge clk);
    uart_rx_done = 1'b0;
    reset_n = 1'b0;
    #1;
    check("rst.wr", fifo_wr_req, 0);
    check("rst.data", fifo_wr_data, 0);
    check("rst.drop", rx_drop, 0);
    check("rst.pend", rx_packet_end, 0);
    check("rst.ovf", ovf_count, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < int'(IDLE) + 4; i++) begin
      cycle(0, 8'h00, 0, 0, 0);
      if (rx_packet_end) seen = 1'b1;
    end
    check("rst.no_pend", seen, 0);

    // Fresh packet after reset: end exactly IDLE clocks after the write.
    cycle(1, 8'hE7, 0, 0, 0);
    check("fresh.wr", fifo_wr_req, 1);
    check("fresh.data", fifo_wr_data, 8'hE7);
    k = 0;
    seen = 1'b0;
    while (!seen && k < 3 * int'(IDLE)) begin
      cycle(0, 8'h00, 0, 0, 0);
      k++;
      if (rx_packet_end) seen = 1'b1;
    end
    check("fresh.pend_seen", seen, 1);
    check("fresh.pend_delay", k, IDLE);
    cycle(0, 8'h00, 0, 0, 0);
    check("fresh.pend_pulse", rx_packet_end, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_uart_recv_ctrl

// File: doc/uart_recv_ctrl.md
# uart_recv_ctrl

- Receive-side companion to the UART transmit path.
- Takes bytes from the UART receiver core (one-cycle done strobe plus data plus framing-error flag) and pushes them into the RX FIFO for downstream consumers.
- Drops bytes on FIFO-full or framing error, and reports each drop.
- Detects inter-byte idle gaps and flags end-of-packet, so software and protocol logic can delimit frames without a length field.

## Interface
- IDLE_CYCLES, 16710, clocks of line silence after the last accepted byte that end a packet (≈3.5 chars at 115200 baud / 50 MHz); legal range 2..2^20-1
- OVF_CNT_W, 8, width of the drop counter
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- uart_rx_done  in  1  one-cycle pulse, byte available on uart_rx_data
- uart_rx_data  in  8  received byte, valid only when uart_rx_done=1
- uart_rx_frame_err  in  1  stop-bit error for the current byte, qualified by uart_rx_done
- fifo_full  in  1  RX FIFO full
- fifo_wr_req  out  1  one-cycle FIFO write strobe
- fifo_wr_data  out  8  byte written, valid with fifo_wr_req
- rx_drop  out  1  one-cycle pulse, byte discarded (full or frame error)
- rx_packet_end  out  1  one-cycle pulse, idle gap closed a packet
- ovf_clear  in  1  synchronous clear of ovf_count
- ovf_count  out  OVF_CNT_W  saturating count of bytes dropped due to fifo_full

## Operation
- Reset (reset_n low): all outputs 0, timer 0, FSM in S_IDLE. Reset mid-packet discards the packet state; no rx_packet_end is issued.
- Byte handling when uart_rx_done=1 in cycle N; all decisions use inputs sampled in cycle N:
  - frame_err=1: drop. rx_drop=1 at N+1, no write. Idle timer is not restarted.
  - frame_err=0, fifo_full=1: drop. rx_drop=1 at N+1, ovf_count increments, idle timer restarts.
  - Otherwise: fifo_wr_req=1 and fifo_wr_data=uart_rx_data at N+1; FSM goes to S_RECV; timer restarts.
- fifo_wr_data holds its last value when fifo_wr_req=0.
- FSM states:
  - S_IDLE: no accepted bytes pending.
  - S_RECV: at least one byte accepted since the last packet end; the timer counts up once per cycle.
  - When the timer reaches IDLE_CYCLES-1 with no uart_rx_done in that cycle: rx_packet_end=1 next cycle, and the FSM returns to S_IDLE.
- Transitions: S_IDLE→S_RECV on an accepted byte; S_RECV→S_RECV on any non-frame-error uart_rx_done (timer cleared); S_RECV→S_IDLE on timeout.
- Simultaneous uart_rx_done and terminal count: the byte wins. Timer clears, no rx_packet_end.
- Timer saturates and does not count in S_IDLE.
- ovf_count saturates at 2^OVF_CNT_W-1.
- ovf_clear and an overflow in the same cycle: the counter becomes 1.

## Timing
- Byte-to-write latency: exactly 1 clock.
- Byte-to-drop latency: exactly 1 clock.
- Back-to-back uart_rx_done on consecutive cycles must be supported: one write per cycle, no internal buffering.
- rx_packet_end occurs exactly IDLE_CYCLES clocks after the fifo_wr_req of the last accepted byte.
- The FIFO write is fire-and-forget. fifo_full must reflect any write issued in the previous cycle, i.e. standard synchronous FIFO full semantics.

## Configuration
- UART_RX_OVF_CNT_EN defined: ovf_count and ovf_clear are functional as described.
- Undefined: counter logic is removed, ovf_count is tied to 0, ovf_clear is ignored. Ports remain, and rx_drop is still generated.

## Structure
- Shared package uart_pkg holds:
  - the FSM state enum (S_IDLE, S_RECV)
  - the byte width constant (8)
  - the default IDLE_CYCLES value; uart_send_ctrl users share the baud/clock constants.
- One sub-module: uart_rx_idle_timer (restart, enable, terminal-count pulse, width from $clog2(IDLE_CYCLES)).

## Test plan
- Single byte 0xA5 with fifo_full=0 → fifo_wr_req at N+1 with 0xA5. After IDLE_CYCLES more clocks, one rx_packet_end pulse.
- Three bytes 0x11, 0x22, 0x33 on consecutive cycles → three consecutive writes in order, a single rx_packet_end, no rx_drop.
- Byte 0x55 with fifo_full=1 → no write, rx_drop pulse, ovf_count 0→1. Repeat 300 times with OVF_CNT_W=8 → ovf_count holds 255.
- Byte with frame_err=1 in S_IDLE → rx_drop, no write, no rx_packet_end ever. Same case in S_RECV → timeout is not extended.
- Byte arriving exactly at terminal count → write occurs, no rx_packet_end, timer restarts.
- Assert reset_n mid-packet, then release → all outputs 0 and no rx_packet_end. Next byte behaves as a fresh packet.
